// File: rtl/vmm_arb.sv
// Single-ported video memory shared between a video read port and a CPU port.
// Video reads win each cycle until a pending CPU access has waited STARVE cycles.
module vmm_arb #(
    parameter int AW     = 14,
    parameter int DW     = 8,
    parameter int STARVE = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          vrd,
    input  logic [AW-1:0] va,
    output logic [DW-1:0] vdo,
    output logic          vmiss,
    input  logic          creq,
    input  logic          cwr,
    input  logic [AW-1:0] ca,
    input  logic [DW-1:0] cdi,
    output logic [DW-1:0] cdo,
    output logic          cack,
    output logic          cbusy
);

    // Handshake: creq is a level sampled only while idle; a captured access
    // is acknowledged by exactly one cack pulse, and cbusy marks it pending.
    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    localparam logic [7:0] STARVE_L = 8'(STARVE);

    state_t        state, state_nxt;
    logic [7:0]    starve_cnt, starve_cnt_nxt;
    logic          hold_wr;
    logic [AW-1:0] hold_a;
    logic [DW-1:0] hold_d;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    logic forced;
    logic do_vid;
    logic do_cpu;
    logic capture;

    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        forced         = (state == PEND) && (starve_cnt == STARVE_L);
        do_vid         = vrd && !forced;
        do_cpu         = (state == PEND) && !do_vid;
        capture        = (state == IDLE) && creq;
        case (state)
            IDLE: begin
                if (creq) begin
                    state_nxt      = PEND;
                    starve_cnt_nxt = '0;
                end
            end
            PEND: begin
                // Not serviced here means a video read took the slot.
                if (do_cpu) begin
                    state_nxt = IDLE;
                end else if (starve_cnt != STARVE_L) begin
                    starve_cnt_nxt = starve_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            vdo        <= '0;
            cdo        <= '0;
            cack       <= 1'b0;
            vmiss      <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
            cack       <= do_cpu;
            vmiss      <= forced && vrd;
            if (do_vid) begin
                vdo <= mem[va];
            end
            if (do_cpu && hold_wr) begin
                cdo <= mem[hold_a];
            end
        end
    end

    // Holding registers need no reset: they are only consumed from PEND.
    always_ff @(posedge clock) begin
        if (reset && capture) begin
            hold_wr <= cwr;
            hold_a  <= ca;
            hold_d  <= cdi;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && do_cpu && !hold_wr) begin
            mem[hold_a] <= hold_d;
        end
    end

    assign cbusy = (state == PEND);

endmodule

// File: tb/tb_vmm_arb.sv
// Bench for vmm_arb: directed scenarios plus randomized traffic checked
// against a transaction-level model of the memory and arbitration rules.
module tb_vmm_arb;

    localparam int AW     = 14;
    localparam int DW     = 8;
    localparam int STARVE = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          vrd   = 1'b0;
    logic [AW-1:0] va    = '0;
    logic [DW-1:0] vdo;
    logic          vmiss;
    logic          creq  = 1'b0;
    logic          cwr   = 1'b1;
    logic [AW-1:0] ca    = '0;
    logic [DW-1:0] cdi   = '0;
    logic [DW-1:0] cdo;
    logic          cack;
    logic          cbusy;

    always #5 clock = ~clock;

    vmm_arb #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
        .clock(clock), .reset(reset),
        .vrd(vrd), .va(va), .vdo(vdo), .vmiss(vmiss),
        .creq(creq), .cwr(cwr), .ca(ca), .cdi(cdi),
        .cdo(cdo), .cack(cack), .cbusy(cbusy)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Scoreboard: expected CPU read data, queued when the read is accepted.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_mem [int];
    bit            m_pend;
    int            m_blocked;
    logic          p_wr;
    logic [AW-1:0] p_a;
    logic [DW-1:0] p_d;
    logic [DW-1:0] e_vdo, e_cdo;
    bit            e_vdo_k;
    logic          e_cack, e_vmiss;

    // Drive one cycle of inputs, advance the model, return at the falling edge.
    task automatic step(input logic rst_n, input logic v, input logic [AW-1:0] vaddr,
                        input logic cq, input logic w_n, input logic [AW-1:0] caddr,
                        input logic [DW-1:0] d);
        bit forced, vid, cpu, was_pend;
        reset = rst_n; vrd = v; va = vaddr; creq = cq; cwr = w_n; ca = caddr; cdi = d;
        if (!rst_n) begin
            m_pend = 0; m_blocked = 0; e_vdo = '0; e_vdo_k = 1; e_cdo = '0;
            e_cack = 1'b0; e_vmiss = 1'b0; exp_q.delete();
        end else begin
            was_pend = m_pend;
            forced   = m_pend && (m_blocked >= STARVE);
            vid      = v && !forced;
            cpu      = m_pend && !vid;
            e_cack   = cpu;
            e_vmiss  = forced && v;
            if (vid) begin
                e_vdo_k = m_mem.exists(int'(vaddr));
                if (e_vdo_k) e_vdo = m_mem[int'(vaddr)];
            end
            if (cpu) begin
                if (!p_wr) m_mem[int'(p_a)] = p_d;
                else       e_cdo = exp_q.pop_front();
                m_pend = 0;
            end else if (m_pend) begin
                m_blocked++;
            end
            if (!was_pend && cq) begin
                m_pend = 1; m_blocked = 0; p_wr = w_n; p_a = caddr; p_d = d;
                if (w_n) exp_q.push_back(m_mem.exists(int'(caddr)) ? m_mem[int'(caddr)] : 'x);
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, '0, 1'b0, 1'b1, '0, '0);
    endtask

    task automatic vread(input logic [AW-1:0] a);
        step(1'b1, 1'b1, a, 1'b0, 1'b1, '0, '0);
    endtask

    task automatic wait_ack(input string tag);
        int n = 0;
        while (cack !== 1'b1 && n < 20) begin
            idle();
            n++;
        end
        n_total++;
        if (cack !== 1'b1) $display("FAIL %s_timeout: cack=%b after %0d cycles, want 1", tag, cack, n);
        else n_pass++;
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, a, d);
        wait_ack("cpu_write");
    endtask

    task automatic cpu_read(input logic [AW-1:0] a);
        step(1'b1, 1'b0, '0, 1'b1, 1'b1, a, '0);
        wait_ack("cpu_read");
    endtask

    function automatic logic [AW-1:0] pick();
        int r = int'($urandom_range(0, 31));
        return (r < 16) ? AW'(r) : AW'(16'h3FF0 + r - 16);
    endfunction

    task automatic test_reset();
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, '0, '0);
        step(1'b0, 1'b1, 14'h0005, 1'b1, 1'b0, 14'h0003, 8'hFF);
        n_total++; if (cbusy !== 1'b0) $display("FAIL reset_cbusy: got %b want 0", cbusy); else n_pass++;
        n_total++; if (cack !== 1'b0) $display("FAIL reset_cack: got %b want 0", cack); else n_pass++;
        n_total++; if (vmiss !== 1'b0) $display("FAIL reset_vmiss: got %b want 0", vmiss); else n_pass++;
        n_total++; if (vdo !== 8'h00) $display("FAIL reset_vdo: got %h want 00", vdo); else n_pass++;
        n_total++; if (cdo !== 8'h00) $display("FAIL reset_cdo: got %h want 00", cdo); else n_pass++;
        idle();
        n_total++; if (cbusy !== 1'b0) $display("FAIL reset_release_cbusy: got %b want 0", cbusy); else n_pass++;
    endtask

    task automatic test_write_video();
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, 14'h1234, 8'h5A);
        n_total++; if ({cbusy, cack} !== 2'b10) $display("FAIL wr_pending: cbusy,cack=%b want 10", {cbusy, cack}); else n_pass++;
        idle();
        n_total++; if ({cbusy, cack} !== 2'b01) $display("FAIL wr_cack_n2: cbusy,cack=%b want 01", {cbusy, cack}); else n_pass++;
        vread(14'h1234);
        n_total++; if (cack !== 1'b0) $display("FAIL wr_cack_single: got %b want 0", cack); else n_pass++;
        n_total++; if (vdo !== 8'h5A) $display("FAIL wr_video_readback: got %h want 5a", vdo); else n_pass++;
    endtask

    task automatic test_blocked_read();
        int busy = 0, acks = 0, miss = 0;
        step(1'b1, 1'b0, '0, 1'b1, 1'b1, 14'h1234, '0);
        for (int i = 0; i < 8; i++) begin
            busy += int'(cbusy); acks += int'(cack); miss += int'(vmiss);
            step(1'b1, (i < 3), 14'h1234, 1'b0, 1'b1, '0, '0);
        end
        busy += int'(cbusy); acks += int'(cack); miss += int'(vmiss);
        n_total++; if (busy != 4) $display("FAIL blk_busy_cycles: got %0d want 4", busy); else n_pass++;
        n_total++; if (acks != 1) $display("FAIL blk_cack_count: got %0d want 1", acks); else n_pass++;
        n_total++; if (miss != 0) $display("FAIL blk_vmiss_count: got %0d want 0", miss); else n_pass++;
        n_total++; if (cdo !== 8'h5A) $display("FAIL blk_cdo: got %h want 5a", cdo); else n_pass++;
    endtask

    task automatic test_forced();
        int busy = 0, acks = 0, miss = 0;
        cpu_write(14'h0010, 8'h11);
        step(1'b1, 1'b1, 14'h1234, 1'b1, 1'b0, 14'h0020, 8'h77);
        for (int i = 0; i < 16; i++) begin
            busy += int'(cbusy); miss += int'(vmiss);
            if (cack === 1'b1) begin
                acks++;
                n_total++; if (vdo !== 8'h5A) $display("FAIL forced_vdo_hold: got %h want 5a", vdo); else n_pass++;
                n_total++; if (vmiss !== 1'b1) $display("FAIL forced_vmiss: got %b want 1", vmiss); else n_pass++;
            end
            step(1'b1, 1'b1, (i % 2 == 1) ? 14'h1234 : 14'h0010, 1'b0, 1'b1, '0, '0);
        end
        n_total++; if (busy != STARVE + 1) $display("FAIL forced_busy_cycles: got %0d want %0d", busy, STARVE + 1); else n_pass++;
        n_total++; if (acks != 1) $display("FAIL forced_cack_count: got %0d want 1", acks); else n_pass++;
        n_total++; if (miss != 1) $display("FAIL forced_vmiss_count: got %0d want 1", miss); else n_pass++;
        vread(14'h0020);
        n_total++; if (vdo !== 8'h77) $display("FAIL forced_write_data: got %h want 77", vdo); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        bit sent = 0;
        logic prev = 1'b0;
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, 14'h0100, 8'hA1);
        for (int i = 0; i < 10; i++) begin
            if (cack === 1'b1 && prev !== 1'b1) pulses++;
            prev = cack;
            if (cack === 1'b1 && !sent) begin
                sent = 1;
                step(1'b1, 1'b0, '0, 1'b1, 1'b0, 14'h0101, 8'hB2);
            end else begin
                idle();
            end
        end
        n_total++; if (pulses != 2) $display("FAIL b2b_cack_pulses: got %0d want 2", pulses); else n_pass++;
        vread(14'h0100);
        n_total++; if (vdo !== 8'hA1) $display("FAIL b2b_first_data: got %h want a1", vdo); else n_pass++;
        vread(14'h0101);
        n_total++; if (vdo !== 8'hB2) $display("FAIL b2b_second_data: got %h want b2", vdo); else n_pass++;
    endtask

    task automatic test_reset_pend();
        int acks = 0;
        cpu_write(14'h0200, 8'h33);
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, 14'h0200, 8'hCC);
        step(1'b0, 1'b1, 14'h0200, 1'b1, 1'b0, 14'h0200, 8'hCC);
        n_total++; if ({cbusy, cack, vmiss} !== 3'b000) $display("FAIL rstp_flags: cbusy,cack,vmiss=%b want 000", {cbusy, cack, vmiss}); else n_pass++;
        n_total++; if ({vdo, cdo} !== 16'h0000) $display("FAIL rstp_data: vdo,cdo=%h want 0000", {vdo, cdo}); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            idle();
            acks += int'(cack);
        end
        n_total++; if (acks != 0) $display("FAIL rstp_no_cack: got %0d want 0", acks); else n_pass++;
        vread(14'h0200);
        n_total++; if (vdo !== 8'h33) $display("FAIL rstp_mem_kept: got %h want 33", vdo); else n_pass++;
    endtask

    task automatic test_corners();
        cpu_write(14'h0000, 8'hA5);
        cpu_write(14'h3FFF, 8'h5C);
        cpu_read(14'h0000);
        n_total++; if (cdo !== 8'hA5) $display("FAIL corner_cpu_lo: got %h want a5", cdo); else n_pass++;
        cpu_read(14'h3FFF);
        n_total++; if (cdo !== 8'h5C) $display("FAIL corner_cpu_hi: got %h want 5c", cdo); else n_pass++;
        vread(14'h0000);
        n_total++; if (vdo !== 8'hA5) $display("FAIL corner_vid_lo: got %h want a5", vdo); else n_pass++;
        vread(14'h3FFF);
        n_total++; if (vdo !== 8'h5C) $display("FAIL corner_vid_hi: got %h want 5c", vdo); else n_pass++;
    endtask

    task automatic test_random();
        logic v;
        for (int a = 0; a < 32; a++) begin
            cpu_write((a < 16) ? AW'(a) : AW'(16'h3FF0 + a - 16), DW'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 1500; i++) begin
            v = ((i % 300) < 120) ? 1'b1 : 1'($urandom_range(0, 1));
            step(1'b1, v, pick(), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 pick(), DW'($urandom_range(0, 255)));
            n_total++; if (cbusy !== m_pend) $display("FAIL rnd_cbusy @%0d: got %b want %b", i, cbusy, m_pend); else n_pass++;
            n_total++; if (cack !== e_cack) $display("FAIL rnd_cack @%0d: got %b want %b", i, cack, e_cack); else n_pass++;
            n_total++; if (vmiss !== e_vmiss) $display("FAIL rnd_vmiss @%0d: got %b want %b", i, vmiss, e_vmiss); else n_pass++;
            if (e_vdo_k) begin
                n_total++; if (vdo !== e_vdo) $display("FAIL rnd_vdo @%0d: got %h want %h", i, vdo, e_vdo); else n_pass++;
            end
            if (!$isunknown(e_cdo)) begin
                n_total++; if (cdo !== e_cdo) $display("FAIL rnd_cdo @%0d: got %h want %h", i, cdo, e_cdo); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_video();
        test_blocked_read();
        test_forced();
        test_back_to_back();
        test_reset_pend();
        test_corners();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
